// File: rtl/sam_task_scheduler.sv
// sam_task_scheduler
// Queues parsed SAM pick/place tasks and hands them to the start/end-point
// decoder one at a time. Each task is tracked through pick completion and
// then place completion. A per-phase watchdog abandons a task that stalls.
// After SUBUNITS_PER_RUN tasks, no further task is issued until the decoder
// accepts a new CSL message.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   msg_valid            one-cycle strobe, new task on msg_pick/msg_place
//   msg_ready            queue can accept a task (registered from the count)
//   csl_seen             decoder accepted a CSL message; starts a new run
//   dec_idle             decoder is waiting for a SAM message
//   dec_pick_done        decoder finished the pick phase
//   dec_place_done       decoder finished the place phase
//   sam_valid            one-cycle issue strobe to the decoder
//   sam_pick/sam_place   nodes of the in-flight task, held until the next pop
//   subunit              number of tasks issued since the last CSL
//   busy                 a task is in flight
//   fifo_count           number of queued entries
//   overflow, timeout    sticky error flags, cleared only by reset
module sam_task_scheduler #(
  parameter int unsigned DEPTH            = 4,
  parameter logic [4:0]  NODE_MAX         = 5'd31,
  parameter int unsigned SUBUNITS_PER_RUN = 3,
  parameter logic [23:0] TIMEOUT_CYCLES   = 24'd10_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     msg_valid,
  input  logic [4:0]               msg_pick,
  input  logic [4:0]               msg_place,
  output logic                     msg_ready,
  input  logic                     csl_seen,
  input  logic                     dec_idle,
  input  logic                     dec_pick_done,
  input  logic                     dec_place_done,
  output logic                     sam_valid,
  output logic [4:0]               sam_pick,
  output logic [4:0]               sam_place,
  output logic [1:0]               subunit,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned NODE_W = 5;
  localparam int unsigned ENT_W  = 2 * NODE_W;
  localparam int unsigned WD_W   = 24;
  localparam int unsigned RUN_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_PICK,
    S_WAIT_PLACE
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               msg_ready_q, msg_ready_d;
  logic [RUN_W-1:0]   issued_q, issued_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               sam_valid_q, sam_valid_d;
  logic [NODE_W-1:0]  sam_pick_q, sam_pick_d;
  logic [NODE_W-1:0]  sam_place_q, sam_place_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               task_ok_c;
  logic               push_c;
  logic               pop_c;
  logic [ENT_W-1:0]   head_c;
  logic               wd_expire_c;
  logic [WD_W-1:0]    wd_inc_c;

  // Task legality and queue handshakes; ready is the registered view of count
  always_comb begin
    task_ok_c = (msg_pick <= NODE_MAX) && (msg_place <= NODE_MAX) &&
                (msg_pick != msg_place);
    push_c    = msg_valid && msg_ready_q && task_ok_c;
    pop_c     = (state_q == S_IDLE) && (count_q != '0) &&
                (issued_q < RUN_W'(SUBUNITS_PER_RUN));
    head_c    = mem_q[rd_ptr_q];
  end

  // Queue pointers, occupancy and the overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (msg_valid && !push_c) overflow_d = 1'b1;
    msg_ready_d = (count_d < CNT_W'(DEPTH));
  end

  // Watchdog helpers: expiry on the last allowed cycle, saturating increment
  always_comb begin
    wd_expire_c = (wd_q == (TIMEOUT_CYCLES - 24'd1));
    wd_inc_c    = (&wd_q) ? wd_q : (wd_q + WD_W'(1));
  end

  // Task sequencing FSM
  always_comb begin
    state_d     = state_q;
    sam_valid_d = 1'b0;
    sam_pick_d  = sam_pick_q;
    sam_place_d = sam_place_q;
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    // A CSL clears the run first; an issue in the same cycle then counts as 1
    issued_d    = csl_seen ? '0 : issued_q;

    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          sam_pick_d  = head_c[ENT_W-1:NODE_W];
          sam_place_d = head_c[NODE_W-1:0];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dec_idle) begin
          sam_valid_d = 1'b1;
          issued_d    = issued_d + RUN_W'(1);
          wd_d        = '0;
          state_d     = S_WAIT_PICK;
        end
      end
      S_WAIT_PICK: begin
        // A place completion here is stale and ignored; pick takes priority
        if (dec_pick_done) begin
          wd_d    = '0;
          state_d = S_WAIT_PLACE;
        end else if (wd_expire_c) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_inc_c;
        end
      end
      S_WAIT_PLACE: begin
        if (dec_place_done) begin
          state_d = S_IDLE;
        end else if (wd_expire_c) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_inc_c;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      msg_ready_q <= 1'b0;
      issued_q    <= '0;
      wd_q        <= '0;
      sam_valid_q <= 1'b0;
      sam_pick_q  <= '0;
      sam_place_q <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      msg_ready_q <= msg_ready_d;
      issued_q    <= issued_d;
      wd_q        <= wd_d;
      sam_valid_q <= sam_valid_d;
      sam_pick_q  <= sam_pick_d;
      sam_place_q <= sam_place_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  // Queue storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= {msg_pick, msg_place};
  end

  assign msg_ready  = msg_ready_q;
  assign sam_valid  = sam_valid_q;
  assign sam_pick   = sam_pick_q;
  assign sam_place  = sam_place_q;
  assign subunit    = issued_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sam_task_scheduler.sv
// Directed bench for sam_task_scheduler with NODE_MAX=20 and a 16-cycle
// watchdog so that range and timeout boundaries are reachable quickly.
module tb_sam_task_scheduler;

  logic       clk;
  logic       rst_n;
  logic       msg_valid;
  logic [4:0] msg_pick;
  logic [4:0] msg_place;
  logic       msg_ready;
  logic       csl_seen;
  logic       dec_idle;
  logic       dec_pick_done;
  logic       dec_place_done;
  logic       sam_valid;
  logic [4:0] sam_pick;
  logic [4:0] sam_place;
  logic [1:0] subunit;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  sam_task_scheduler #(
    .DEPTH            (4),
    .NODE_MAX         (5'd20),
    .SUBUNITS_PER_RUN (3),
    .TIMEOUT_CYCLES   (24'd16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .msg_valid      (msg_valid),
    .msg_pick       (msg_pick),
    .msg_place      (msg_place),
    .msg_ready      (msg_ready),
    .csl_seen       (csl_seen),
    .dec_idle       (dec_idle),
    .dec_pick_done  (dec_pick_done),
    .dec_place_done (dec_place_done),
    .sam_valid      (sam_valid),
    .sam_pick       (sam_pick),
    .sam_place      (sam_place),
    .subunit        (subunit),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] p, input logic [4:0] l);
    msg_valid = 1'b1;
    msg_pick  = p;
    msg_place = l;
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic pulse_pick();
    dec_pick_done = 1'b1;
    tick();
    dec_pick_done = 1'b0;
  endtask

  task automatic pulse_place();
    dec_place_done = 1'b1;
    tick();
    dec_place_done = 1'b0;
  endtask

  task automatic pulse_csl();
    csl_seen = 1'b1;
    tick();
    csl_seen = 1'b0;
  endtask

  // Bounded wait for the issue strobe
  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (sam_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(sam_valid), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_count", 32'(fifo_count), 0);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; msg_valid = 1'b0; msg_pick = '0; msg_place = '0;
    csl_seen = 1'b0; dec_idle = 1'b0; dec_pick_done = 1'b0; dec_place_done = 1'b0;
    #3;
    // Reset state
    chk("reset_msg_ready", 32'(msg_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_fifo_count", 32'(fifo_count), 0);
    chk("reset_sam_valid", 32'(sam_valid), 0);
    chk("reset_subunit", 32'(subunit), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_timeout", 32'(timeout), 0);
    #4;
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'(msg_ready), 1);

    // 1: single task end to end
    dec_idle = 1'b1;
    push(5'd4, 5'd9);
    chk("t1_count_after_push", 32'(fifo_count), 1);
    tick();
    chk("t1_popped_count", 32'(fifo_count), 0);
    chk("t1_no_valid_in_issue_entry", 32'(sam_valid), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_sam_valid", 32'(sam_valid), 1);
    chk("t1_sam_pick", 32'(sam_pick), 4);
    chk("t1_sam_place", 32'(sam_place), 9);
    chk("t1_subunit", 32'(subunit), 1);
    tick();
    chk("t1_valid_one_cycle", 32'(sam_valid), 0);
    pulse_pick();
    chk("t1_busy_wait_place", 32'(busy), 1);
    pulse_place();
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_count_end", 32'(fifo_count), 0);
    chk("t1_pick_held", 32'(sam_pick), 4);

    // 4: illegal tasks are dropped and flagged
    chk("t4_overflow_clear", 32'(overflow), 0);
    push(5'd7, 5'd7);
    chk("t4_same_node_overflow", 32'(overflow), 1);
    chk("t4_same_node_count", 32'(fifo_count), 0);
    do_reset();
    push(5'd3, 5'd21);
    chk("t4_range_overflow", 32'(overflow), 1);
    chk("t4_range_count", 32'(fifo_count), 0);
    do_reset();

    // 2: fill the queue while the decoder is busy
    dec_idle = 1'b0;
    push(5'd20, 5'd0);
    push(5'd2, 5'd3);
    chk("t2_push_pop_same_cycle", 32'(fifo_count), 1);
    push(5'd3, 5'd4);
    push(5'd4, 5'd5);
    chk("t2_ready_at_3", 32'(msg_ready), 1);
    push(5'd5, 5'd6);
    chk("t2_count_full", 32'(fifo_count), 4);
    chk("t2_ready_full", 32'(msg_ready), 0);
    chk("t2_no_overflow_yet", 32'(overflow), 0);
    push(5'd6, 5'd7);
    chk("t2_overflow_full", 32'(overflow), 1);
    chk("t2_count_stays", 32'(fifo_count), 4);

    // 3: run limit and CSL release
    pulse_csl();
    chk("t3_subunit_after_csl", 32'(subunit), 0);
    dec_idle = 1'b1;
    wait_valid("t3_a_valid");
    chk("t3_a_pick", 32'(sam_pick), 20);
    chk("t3_a_place", 32'(sam_place), 0);
    chk("t3_a_subunit", 32'(subunit), 1);
    pulse_pick();
    pulse_place();
    wait_valid("t3_b_valid");
    chk("t3_b_pick", 32'(sam_pick), 2);
    chk("t3_b_subunit", 32'(subunit), 2);
    pulse_place();
    chk("t3_place_ignored_in_pick", 32'(busy), 1);
    pulse_pick();
    pulse_place();
    wait_valid("t3_c_valid");
    chk("t3_c_pick", 32'(sam_pick), 3);
    pulse_pick();
    chk("t3_c_subunit_in_place", 32'(subunit), 3);
    pulse_place();
    chk("t3_c_done", 32'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_blocked_busy", 32'(busy), 0);
      chk("t3_blocked_valid", 32'(sam_valid), 0);
    end
    chk("t3_blocked_count", 32'(fifo_count), 2);
    pulse_csl();
    wait_valid("t3_d_valid");
    chk("t3_d_pick", 32'(sam_pick), 4);
    chk("t3_d_place", 32'(sam_place), 5);
    chk("t3_d_subunit", 32'(subunit), 1);
    dec_pick_done = 1'b1;
    dec_place_done = 1'b1;
    tick();
    dec_pick_done = 1'b0;
    dec_place_done = 1'b0;
    chk("t3_both_done_pick_only", 32'(busy), 1);
    pulse_place();
    chk("t3_d_done", 32'(busy), 0);

    // 5: watchdog in the pick phase
    wait_valid("t5_valid");
    chk("t5_pick", 32'(sam_pick), 5);
    chk("t5_subunit", 32'(subunit), 2);
    push(5'd8, 5'd9);
    for (int i = 0; i < 14; i++) tick();
    chk("t5_no_timeout_15", 32'(timeout), 0);
    chk("t5_busy_15", 32'(busy), 1);
    tick();
    chk("t5_timeout_16", 32'(timeout), 1);
    chk("t5_idle_after_timeout", 32'(busy), 0);
    chk("t5_queued", 32'(fifo_count), 1);
    wait_valid("t5_next_valid");
    chk("t5_next_pick", 32'(sam_pick), 8);
    chk("t5_next_place", 32'(sam_place), 9);
    chk("t5_next_subunit", 32'(subunit), 3);

    // 6: asynchronous reset mid-task
    push(5'd10, 5'd11);
    push(5'd12, 5'd13);
    pulse_pick();
    chk("t6_count", 32'(fifo_count), 2);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_overflow_set", 32'(overflow), 1);
    chk("t6_timeout_set", 32'(timeout), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_count_rst", 32'(fifo_count), 0);
    chk("t6_overflow_rst", 32'(overflow), 0);
    chk("t6_timeout_rst", 32'(timeout), 0);
    chk("t6_subunit_rst", 32'(subunit), 0);
    chk("t6_pick_rst", 32'(sam_pick), 0);
    chk("t6_ready_rst", 32'(msg_ready), 0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sam_task_scheduler.md
Name: sam_task_scheduler

Overview:
- Buffers parsed SAM pick/place tasks in a small FIFO.
- Issues them one at a time to the start/end-point decoder, sequences each task through pick and place completion, and supplies the per-run subunit index.
- Blocks further issue after SUBUNITS_PER_RUN tasks until a new CSL message is accepted.
- Sits between the SAM message parser and the decoder; includes a per-phase watchdog.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
NODE_MAX, 5'd31, highest legal node id; tasks with pick or place > NODE_MAX are rejected
SUBUNITS_PER_RUN, 3, tasks issued per CSL run (1..3)
TIMEOUT_CYCLES, 24'd10_000_000, watchdog limit per pick/place phase

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
msg_valid  in  1  one-cycle strobe: new SAM task present
msg_pick  in  5  pick node of task
msg_place  in  5  place node of task
msg_ready  out  1  FIFO can accept (count < DEPTH)
csl_seen  in  1  one-cycle strobe: decoder accepted a CSL message (new run)
dec_idle  in  1  decoder is waiting for a SAM message
dec_pick_done  in  1  decoder activate_pick_operation
dec_place_done  in  1  decoder activate_place_operation
sam_valid  out  1  one-cycle issue strobe to decoder
sam_pick  out  5  pick node of in-flight task, held stable
sam_place  out  5  place node of in-flight task, held stable
subunit  out  2  index of current/last task in run (0 = none since CSL)
busy  out  1  task in flight (state != IDLE)
fifo_count  out  3  entries queued
overflow  out  1  sticky: task dropped (FIFO full or invalid)
timeout  out  1  sticky: watchdog expired

Behaviour:
Reset (rst_n low, async):
- FSM=IDLE, FIFO empty, all outputs 0.
- Only rst_n clears the sticky flags overflow and timeout.

Push:
- On msg_valid, the task is written if msg_ready=1 and it is valid.
- Valid task: pick<=NODE_MAX, place<=NODE_MAX, pick!=place.
- Otherwise the task is dropped and overflow is set.
- Push and pop in the same cycle are allowed; count is unchanged.
- msg_valid while full: dropped even if a pop occurs that cycle (msg_ready is registered from count).

Run counter:
- issued (0..SUBUNITS_PER_RUN), cleared by csl_seen.
- subunit = issued.

FSM:
- IDLE: if fifo not empty and issued<SUBUNITS_PER_RUN, pop the head into sam_pick/sam_place and go to ISSUE. If issued==SUBUNITS_PER_RUN, hold (tasks stay queued) until csl_seen.
- ISSUE: wait for dec_idle=1. In that cycle:
  - sam_valid=1 for exactly one cycle
  - issued increments, so subunit reflects this task before the decoder samples it at place arrival
  - clear watchdog; go to WAIT_PICK.
- WAIT_PICK: on dec_pick_done, clear watchdog and go to WAIT_PLACE.
- WAIT_PLACE: on dec_place_done, go to IDLE. sam_pick/sam_place hold their last values.
- Watchdog in WAIT_PICK/WAIT_PLACE: counts every cycle. On reaching TIMEOUT_CYCLES-1, set timeout and go to IDLE; the task is abandoned and not retried.

Latency:
- Push to IDLE pop: 1 cycle (FIFO registered).
- Pop to sam_valid: >=1 cycle, earliest the cycle after entering ISSUE with dec_idle high.

Simultaneous events:
- csl_seen in the same cycle as an issue: clear wins, then the issue counts, so issued=1.
- csl_seen mid-task: issued clears to 0; the FSM continues the in-flight task unchanged.
- dec_place_done seen in WAIT_PICK: ignored.
- dec_pick_done and dec_place_done together in WAIT_PICK: only the pick is taken.

Widths:
- fifo_count is $clog2(DEPTH)+1 bits (3 for default DEPTH); pointers wrap modulo DEPTH.
- Watchdog is 24 bits, saturating.

Test Plan:
1. Reset, push (4,9), dec_idle=1 -> sam_valid one cycle with sam_pick=4, sam_place=9, subunit=1. dec_pick_done then dec_place_done -> busy falls, fifo_count=0.
2. Push 5 tasks back-to-back with FSM blocked (dec_idle=0) -> one popped into ISSUE, 4 queued, then msg_ready=0. A 6th push sets overflow, fifo_count stays 4.
3. Complete 3 tasks with 4 queued -> subunit=3 during the 3rd place. The 4th is not issued until csl_seen, then issues with subunit=1.
4. Push (7,7) and (3,33 truncated to 1; use NODE_MAX=20 with 21) -> rejected, overflow=1, fifo_count=0.
5. Issue a task, withhold dec_pick_done with TIMEOUT_CYCLES=16 -> timeout=1 after 16 cycles in WAIT_PICK, FSM IDLE, next task issues.
6. Assert rst_n low during WAIT_PLACE with 2 queued -> outputs 0, fifo_count=0, overflow/timeout cleared immediately (async).
